// File: rtl/i2s_dac_out.sv
// i2s_dac_out: buffers 12-bit mono samples in a FIFO and serialises them as 16-bit I2S stereo frames.
// Define I2S_DAC_OUT_UNDERRUN_HOLD_EN to repeat the last word on underrun instead of sending silence.
module i2s_dac_out #(
  parameter int BCLK_HALF  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        main_clk,
  input  logic        rst_n,
  input  logic        sample_clk,
  input  logic [11:0] din,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        overflow,
  output logic        underrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BCLK_HALF);
  logic [CW-1:0] div_q;
  logic          bclk_q, lrclk_q, sdata_q, ovf_q, und_q;
  logic [4:0]    slot_q, slot_d;
  logic [30:0]   sh_q;
  logic [31:0]   sh_d;
  logic [2:0]    sync_q;
  logic [11:0]   din1_q, din2_q;
  logic [AW:0]   wr_q, rd_q;
  logic [11:0]   mem_q [FIFO_DEPTH];
  logic          wrap, fall, load, push, pop, empty, full, wr_en;
  logic [15:0]   hold_w, word;
  always_comb begin
    wrap   = div_q == CW'(BCLK_HALF - 1);
    fall   = wrap & bclk_q;
    slot_d = slot_q + 5'd1;
    load   = fall & (slot_d == 5'd1);
    push   = sync_q[1] & ~sync_q[2];
    empty  = wr_q == rd_q;
    full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop    = load & ~empty;
    wr_en  = push & (~full | pop);
    word   = pop ? {mem_q[rd_q[AW-1:0]], 4'b0000} : hold_w;
    sh_d   = load ? {word, word} : {sh_q, 1'b0};
  end
`ifdef I2S_DAC_OUT_UNDERRUN_HOLD_EN
  logic [15:0] hold_q;
  always_ff @(posedge main_clk or negedge rst_n)
    if (!rst_n) hold_q <= '0;
    else if (pop) hold_q <= word;
  assign hold_w = hold_q;
`else
  assign hold_w = 16'h0000;
`endif
  // The data pipeline runs beside the synchroniser so the pushed sample matches the detected edge.
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
      slot_q  <= '0;
      sh_q    <= '0;
      sync_q  <= '0;
      din1_q  <= '0;
      din2_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      div_q  <= wrap ? '0 : div_q + 1'b1;
      sync_q <= {sync_q[1:0], sample_clk};
      din1_q <= din;
      din2_q <= din1_q;
      if (wrap) bclk_q <= ~bclk_q;
      if (fall) begin
        slot_q  <= slot_d;
        lrclk_q <= slot_d[4];
        sh_q    <= sh_d[30:0];
        sdata_q <= sh_d[31];
      end
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      ovf_q <= push & full & ~pop;
      und_q <= load & empty;
    end
  end
  always_ff @(posedge main_clk)
    if (wr_en) mem_q[wr_q[AW-1:0]] <= din2_q;
  assign i2s_bclk  = bclk_q;
  assign i2s_lrclk = lrclk_q;
  assign i2s_sdata = sdata_q;
  assign overflow  = ovf_q;
  assign underrun  = und_q;
endmodule
